// File: rtl/la_wb_bridge.sv
// Bridges a toggle-handshake request carried on 128 logic-analyzer lines onto a
// single-transaction Wishbone initiator, reporting rdata/done/busy/timeout back.
module la_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oen,
    output logic [127:0] la_data_out,
    output logic         wba_cyc_o,
    output logic         wba_stb_o,
    output logic         wba_we_o,
    output logic [3:0]   wba_sel_o,
    output logic [15:0]  wba_adr_o,
    output logic [31:0]  wba_dat_o,
    input  logic         wba_ack_i,
    input  logic [31:0]  wba_dat_i,
    output logic [1:0]   dbg_state_o
);

    // Handshake: a request is a change of bit 53 relative to req_q; completion
    // is a change of done (bit 32). The Wishbone side holds cyc/stb until ack.
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_BUS  = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [15:0]   adr_q, adr_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q;

    logic          pending;
    logic          to_hit;
    logic          unused_bits;

    assign pending     = !la_oen[53] && (la_data_in[53] != req_q);
    assign to_hit      = (state_q == S_BUS) && !wba_ack_i && (cnt_q == TO_LAST);
    assign unused_bits = ^{la_data_in[127:54], la_oen[127:54]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            req_q     <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_d == S_BUS);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: if (pending) state_d = S_BUS;
            S_BUS:  if (wba_ack_i || to_hit) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Ack is checked before the timeout so a coincident ack completes normally.
    always_comb begin
        req_d     = req_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_INIT: req_d = la_data_in[53];
            S_IDLE: begin
                if (pending) begin
                    adr_d     = la_data_in[47:32] & ~la_oen[47:32];
                    sel_d     = la_data_in[51:48] & ~la_oen[51:48];
                    we_d      = la_data_in[52] & ~la_oen[52];
                    wdata_d   = la_data_in[31:0] & ~la_oen[31:0];
                    req_d     = la_data_in[53];
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_BUS: begin
                if (wba_ack_i) begin
                    done_d = ~done_q;
                    if (!we_q) rdata_d = wba_dat_i;
                end else if (to_hit) begin
                    done_d    = ~done_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wba_cyc_o = 1'b0;
        wba_stb_o = 1'b0;
        wba_we_o  = 1'b0;
        wba_sel_o = '0;
        wba_adr_o = '0;
        wba_dat_o = '0;
        if (state_q == S_BUS) begin
            wba_cyc_o = 1'b1;
            wba_stb_o = 1'b1;
            wba_we_o  = we_q;
            wba_sel_o = sel_q;
            wba_adr_o = adr_q;
            wba_dat_o = wdata_q;
        end
    end

    assign la_data_out = {93'd0, timeout_q, busy_q, done_q, rdata_q};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_la_wb_bridge.sv
// Bench for la_wb_bridge: directed requests, a scripted Wishbone target, and a
// monitor that matches bus cycles and done toggles against expected queues.
module tb_la_wb_bridge;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] la_data_in;
    logic [127:0] la_oen;
    logic [127:0] la_data_out;
    logic         wba_cyc_o, wba_stb_o, wba_we_o;
    logic [3:0]   wba_sel_o;
    logic [15:0]  wba_adr_o;
    logic [31:0]  wba_dat_o;
    logic         wba_ack_i;
    logic [31:0]  wba_dat_i;
    logic [1:0]   dbg_state_o;

    la_wb_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .la_data_in(la_data_in), .la_oen(la_oen), .la_data_out(la_data_out),
        .wba_cyc_o(wba_cyc_o), .wba_stb_o(wba_stb_o), .wba_we_o(wba_we_o),
        .wba_sel_o(wba_sel_o), .wba_adr_o(wba_adr_o), .wba_dat_o(wba_dat_o),
        .wba_ack_i(wba_ack_i), .wba_dat_i(wba_dat_i), .dbg_state_o(dbg_state_o)
    );

    always #5 clock = ~clock;

    // status word {timeout, busy, rdata}; bus word {stb, we, sel, adr, dat}
    logic [33:0] exp_q[$];
    logic [53:0] bus_q[$];
    int checks = 0;
    int failures = 0;
    int ack_delay = 0;
    int bus_cnt = 0;
    int rises = 0;
    int n_done = 0;
    int cur_len = 0;
    int last_len = 0;
    int gap = 0;
    int last_gap = 0;
    logic cyc_prev = 1'b0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Target: ack in the ack_delay-th BUS cycle (0 = never); data depends on address.
    initial begin
        wba_ack_i = 1'b0;
        wba_dat_i = '0;
        forever begin
            @(negedge clock);
            if (wba_cyc_o) begin
                bus_cnt++;
                wba_ack_i = (ack_delay != 0) && (bus_cnt == ack_delay);
                wba_dat_i = (wba_adr_o == 16'h0010) ? 32'hCAFEF00D : {16'hBEEF, wba_adr_o};
            end else begin
                bus_cnt = 0;
                wba_ack_i = 1'b0;
            end
        end
    end

    // Monitor: pops on every cyc rise and every done toggle.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                done_prev = la_data_out[32];
                cyc_prev = wba_cyc_o;
                cur_len = 0;
            end else begin
                if (wba_cyc_o) begin
                    cur_len++;
                    if (!cyc_prev) begin
                        rises++;
                        last_gap = gap;
                        if (bus_q.size() > 0)
                            check("bus_req", 64'({wba_stb_o, wba_we_o, wba_sel_o, wba_adr_o, wba_dat_o}),
                                  64'(bus_q.pop_front()));
                        else begin
                            checks++; failures++;
                            $display("FAIL bus_unexpected actual=adr %h required=none", wba_adr_o);
                        end
                    end
                end else begin
                    if (cyc_prev) begin
                        last_len = cur_len;
                        cur_len = 0;
                        gap = 1;
                    end else gap++;
                end
                if (la_data_out[32] != done_prev) begin
                    n_done++;
                    if (exp_q.size() > 0)
                        check("status", 64'({la_data_out[34:33], la_data_out[31:0]}), 64'(exp_q.pop_front()));
                    else begin
                        checks++; failures++;
                        $display("FAIL done_unexpected actual=toggle required=none");
                    end
                end
                done_prev = la_data_out[32];
                cyc_prev = wba_cyc_o;
            end
        end
    end

    task automatic set_fields(input logic [15:0] adr, input logic [3:0] sel, input logic we,
                              input logic [31:0] wdata);
        la_data_in[47:32] = adr;
        la_data_in[51:48] = sel;
        la_data_in[52]    = we;
        la_data_in[31:0]  = wdata;
    endtask

    task automatic issue(input logic [15:0] adr, input logic [3:0] sel, input logic we,
                         input logic [31:0] wdata, input int adly, input logic push_exp,
                         input logic [33:0] exp_status);
        bus_q.push_back({1'b1, we, sel, adr, wdata});
        if (push_exp) exp_q.push_back(exp_status);
        @(negedge clock);
        set_fields(adr, sel, we, wdata);
        ack_delay = adly;
        la_data_in[53] = ~la_data_in[53];
    endtask

    task automatic wait_done();
        int target = n_done + 1;
        int k = 0;
        while (n_done < target && k < 40) begin
            @(posedge clock);
            k++;
        end
        if (n_done < target) begin
            checks++; failures++;
            $display("FAIL done_wait actual=no_toggle required=toggle");
        end
    endtask

    task automatic wait_busy();
        int k = 0;
        @(negedge clock);
        while (!la_data_out[33] && k < 40) begin
            @(negedge clock);
            k++;
        end
        if (!la_data_out[33]) begin
            checks++; failures++;
            $display("FAIL busy_wait actual=0 required=1");
        end
    endtask

    initial begin
        int r;
        int d;
        la_oen = '0;
        la_data_in = '0;
        la_data_in[53] = 1'b1;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset_status", 64'(la_data_out), 64'd0);
        check("reset_bus", 64'({wba_cyc_o, wba_stb_o, wba_we_o, wba_sel_o, wba_adr_o, wba_dat_o}), 64'd0);
        check("reset_state", 64'(dbg_state_o), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("no_spurious_req", 64'(rises), 64'd0);
        check("idle_state", 64'(dbg_state_o), 64'd1);

        // Read with ack in the 4th BUS cycle: coincides with timeout count, ack wins.
        issue(16'h0010, 4'hF, 1'b0, 32'h0, 4, 1'b1, {2'b00, 32'hCAFEF00D});
        wait_done();
        check("read_len", 64'(last_len), 64'd4);

        issue(16'h0204, 4'h1, 1'b1, 32'h000000A5, 1, 1'b1, {2'b00, 32'hCAFEF00D});
        wait_done();
        check("write_len", 64'(last_len), 64'd1);

        issue(16'h0300, 4'h3, 1'b0, 32'h0, 0, 1'b1, {2'b10, 32'hCAFEF00D});
        wait_done();
        check("timeout_len", 64'(last_len), 64'd4);

        issue(16'h0008, 4'hF, 1'b0, 32'h0, 1, 1'b1, {2'b00, 32'hBEEF0008});
        wait_done();

        // Re-toggle during BUS: second cycle after exactly one IDLE cycle.
        issue(16'h0040, 4'hF, 1'b0, 32'h0, 3, 1'b1, {2'b00, 32'hBEEF0040});
        bus_q.push_back({1'b1, 1'b0, 4'hF, 16'h0044, 32'h0});
        exp_q.push_back({2'b00, 32'hBEEF0044});
        wait_busy();
        la_data_in[47:32] = 16'h0044;
        la_data_in[53] = ~la_data_in[53];
        wait_done();
        wait_done();
        check("retoggle_gap", 64'(last_gap), 64'd1);
        repeat (2) @(negedge clock);
        check("retoggle_len", 64'(last_len), 64'd3);

        // Double toggle during BUS leaves nothing pending.
        issue(16'h0050, 4'hF, 1'b0, 32'h0, 4, 1'b1, {2'b00, 32'hBEEF0050});
        wait_busy();
        la_data_in[53] = ~la_data_in[53];
        @(negedge clock);
        la_data_in[53] = ~la_data_in[53];
        wait_done();
        r = rises;
        repeat (6) @(negedge clock);
        check("double_toggle_quiet", 64'(rises), 64'(r));

        // Masked request bit, then masked address field.
        la_oen[53] = 1'b1;
        la_data_in[53] = ~la_data_in[53];
        r = rises;
        repeat (6) @(negedge clock);
        check("masked_req_quiet", 64'(rises), 64'(r));
        set_fields(16'h1234, 4'hF, 1'b0, 32'h0);
        ack_delay = 1;
        la_oen[47:32] = 16'hFFFF;
        bus_q.push_back({1'b1, 1'b0, 4'hF, 16'h0000, 32'h0});
        exp_q.push_back({2'b00, 32'hBEEF0000});
        la_oen[53] = 1'b0;
        wait_done();
        @(negedge clock);
        la_oen = '0;

        issue(16'h0100, 4'hF, 1'b1, 32'h11112222, 1, 1'b1, {2'b00, 32'hBEEF0000});
        wait_done();

        // Reset mid-BUS with request bit 1: abandoned, no done, no restart.
        issue(16'h0060, 4'hF, 1'b0, 32'h0, 0, 1'b0, 34'd0);
        check("req_bit_one", 64'(la_data_in[53]), 64'd1);
        wait_busy();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst_bus", 64'({wba_cyc_o, wba_stb_o}), 64'd0);
        check("async_rst_status", 64'(la_data_out), 64'd0);
        check("async_rst_state", 64'(dbg_state_o), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        r = rises;
        d = n_done;
        repeat (8) @(negedge clock);
        check("post_rst_no_bus", 64'(rises), 64'(r));
        check("post_rst_no_done", 64'(n_done), 64'(d));
        check("post_rst_status", 64'(la_data_out), 64'd0);

        check("done_total", 64'(n_done), 64'd9);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/la_wb_bridge.md
LA_WB_BRIDGE -- requirements
Module: la_wb_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, range 1..255; cycles BUS waits for wba_ack_i before abort.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 la_data_in  input  128  LA request fields: [31:0] wdata, [47:32] adr, [51:48] sel, [52] we, [53] req toggle.
REQ-005 la_oen  input  128  LA enables, active-low; a field bit is valid only when its la_oen bit is 0.
REQ-006 la_data_out  output  128  status: [31:0] rdata, [32] done toggle, [33] busy, [34] timeout; [127:35] tied 0.
REQ-007 wba_cyc_o, wba_stb_o, wba_we_o  output  1 each  Wishbone initiator cycle/strobe/write.
REQ-008 wba_sel_o  output  4  byte selects.
REQ-009 wba_adr_o  output  16  byte address.
REQ-010 wba_dat_o  output  32  write data.
REQ-011 wba_ack_i  input  1  target acknowledge.
REQ-012 wba_dat_i  input  32  read data.

Function
REQ-013 States: INIT, IDLE, BUS; reset enters INIT.
REQ-014 INIT: lasts exactly one cycle; req_q <= la_data_in[53]; no bus cycle issued; next IDLE.
REQ-015 Request pending in IDLE when la_oen[53]==0 and la_data_in[53] != req_q.
REQ-016 On a pending request at edge N: capture adr/sel/we/wdata into registers; req_q <= la_data_in[53]; timeout flag <= 0; state <= BUS.
REQ-017 A field whose la_oen bit is 1 is captured as 0.
REQ-018 In BUS, wba_cyc_o = wba_stb_o = 1 and adr/sel/we/dat outputs hold the captured values, starting the cycle after edge N.
REQ-019 In IDLE and INIT, wba_cyc_o = wba_stb_o = wba_we_o = 0; wba_sel_o = 0; wba_adr_o = 0; wba_dat_o = 0.
REQ-020 In BUS, the edge that samples wba_ack_i == 1: state <= IDLE; done toggles; on a read (we == 0), rdata <= wba_dat_i; on a write, rdata unchanged.
REQ-021 Minimum request-to-done latency is 2 edges: accept at N, ack sampled at N+1 gives done at N+1.
REQ-022 Timeout counter: 8 bits; cleared on accept; increments each BUS cycle without ack.
REQ-023 When the counter reaches TIMEOUT_CYCLES without ack: state <= IDLE; timeout <= 1; done toggles; rdata unchanged.
REQ-024 If ack and timeout coincide on the same edge, ack wins and timeout stays 0.
REQ-025 busy = (state == BUS), registered.
REQ-026 req_q updates only on accept.
REQ-027 A toggle during BUS stays pending and is accepted in the first IDLE cycle if la_data_in[53] still differs from req_q.
REQ-028 A double toggle during BUS leaves no pending request.
REQ-029 One transaction outstanding at most; no back-to-back without an IDLE cycle between.
REQ-030 wba_ack_i outside BUS is ignored.

Reset
REQ-031 Asserting reset immediately, without waiting for clock, forces: state INIT, wba_cyc_o = wba_stb_o = wba_we_o = 0, wba_sel_o = wba_adr_o = wba_dat_o = 0, rdata = 0, done = 0, busy = 0, timeout = 0, req_q = 0, counter = 0.
REQ-032 Reset during BUS abandons the transaction with no done toggle.
REQ-033 After reset is released, la_data_in[53] = 1 does not cause a spurious request (INIT resyncs req_q).

Verification
REQ-034 Read: adr = 0x0010, sel = 0xF, we = 0, toggle req; target acks 3 cycles later with 0xCAFE_F00D -> cyc/stb high for exactly 4 cycles, rdata = 0xCAFEF00D, done toggles once, busy back to 0, timeout = 0.
REQ-035 Write: adr = 0x0204, wdata = 0x0000_00A5, sel = 0x1, we = 1, immediate ack -> one-cycle cyc/stb with dat_o = 0xA5, we_o = 1; done toggles; rdata unchanged.
REQ-036 Timeout with TIMEOUT_CYCLES = 4 and no ack -> cyc/stb drop after 4 BUS cycles, timeout = 1, done toggles; the next accepted request clears timeout to 0.
REQ-037 Toggle req again while BUS -> second transaction starts after exactly one IDLE cycle; done toggles twice overall.
REQ-038 la_oen[53] = 1 while toggling -> no bus activity; la_oen[47:32] = 0xFFFF -> issued wba_adr_o = 0x0000.
REQ-039 Assert reset mid-BUS with req bit = 1 -> cyc/stb low asynchronously; after release, no new transaction and no done toggle.
